// File: rtl/grid_io_bank_dbuf.sv
// Bottom-edge IO bank: NUM_IO pad subtiles configured through a double-buffered ccff chain.
// Latency: head->shadow[0] one prog_clk, head->tail TOTAL cycles, commit visible the cycle after load.
// No backpressure: shift/load act every edge; a load with the wrong bit count is refused and flagged.
module grid_io_bank_dbuf #(
  parameter int NUM_IO   = 9,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              IO_ISOL_N,
  input  logic              ccff_en,
  input  logic              ccff_load,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad_upper,
  output logic [NUM_IO-1:0] io_inpad_lower,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int TOTAL = NUM_IO * CFG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL + 1);

  logic [TOTAL-1:0]  r_shadow;
  logic [TOTAL-1:0]  r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cfg_valid;
  logic              r_cfg_err;

  logic              w_safe;
  logic [NUM_IO-1:0] w_oe;
  logic [NUM_IO-1:0] w_inv;
  logic [NUM_IO-1:0] w_dir;
  logic [NUM_IO-1:0] w_out;
  logic [NUM_IO-1:0] w_inpad;

  // Config chain: load has priority over shift and only commits an exactly-full shadow.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else if (ccff_load) begin
      // Counter restarts on every load attempt; shadow is left intact either way.
      r_cnt <= '0;
      if (r_cnt == CNT_FULL) begin
        r_active    <= r_shadow;
        r_cfg_valid <= 1'b1;
        r_cfg_err   <= 1'b0;
      end else begin
        r_cfg_err   <= 1'b1;
      end
    end else if (ccff_en) begin
      r_shadow <= {r_shadow[TOTAL-2:0], ccff_head};
      // Saturate one past full so an overshift can never alias back to a valid count.
      if (r_cnt != CNT_OVER) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ccff_tail = r_shadow[TOTAL-1];
  assign cfg_valid = r_cfg_valid;
  assign cfg_err   = r_cfg_err;

  // Pads are forced safe until a config is committed, or while isolated.
  assign w_safe = ~IO_ISOL_N | ~r_cfg_valid;

  // Per-subtile pad steering from the active config only, so shifting never disturbs the pads.
  always_comb begin
    w_oe    = '0;
    w_inv   = '0;
    w_dir   = '0;
    w_out   = '0;
    w_inpad = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      w_oe[i]    = r_active[i*CFG_BITS];
      w_inv[i]   = r_active[i*CFG_BITS+1];
      w_dir[i]   = w_safe | ~w_oe[i];
      w_out[i]   = (w_safe | ~w_oe[i]) ? 1'b0 : (io_outpad[i] ^ w_inv[i]);
      w_inpad[i] = (w_safe |  w_oe[i]) ? 1'b0 : (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i] ^ w_inv[i]);
    end
  end

  assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = w_dir;
  assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = w_out;
  assign io_inpad_upper                   = w_inpad;
  assign io_inpad_lower                   = w_inpad;

endmodule

// File: tb/tb_grid_io_bank_dbuf.sv
// Directed bench for grid_io_bank_dbuf with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares them.
// The bench idles one cycle after each expectation so the monitor sees settled inputs.
module tb_grid_io_bank_dbuf;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n;
  logic       IO_ISOL_N;
  logic       ccff_en;
  logic       ccff_load;
  logic       ccff_head;
  logic       ccff_tail;
  logic [8:0] pad_in;
  logic [8:0] pad_out;
  logic [8:0] pad_dir;
  logic [8:0] io_outpad;
  logic [8:0] io_inpad_upper;
  logic [8:0] io_inpad_lower;
  logic       cfg_valid;
  logic       cfg_err;

  grid_io_bank_dbuf #(.NUM_IO(9), .CFG_BITS(2)) dut (
    .prog_clk                         (prog_clk),
    .prog_reset_n                     (prog_reset_n),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_en                          (ccff_en),
    .ccff_load                        (ccff_load),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .io_outpad                        (io_outpad),
    .io_inpad_upper                   (io_inpad_upper),
    .io_inpad_lower                   (io_inpad_lower),
    .cfg_valid                        (cfg_valid),
    .cfg_err                          (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [8:0] dir;
    logic [8:0] out;
    logic [8:0] inp;
    logic       vld;
    logic       err;
    logic       tail;
    logic       tail_care;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Configurations (shadow image, subtile i bits at [2i+1:2i] = {inv, oe}).
  logic [17:0] CFG_A = 18'h00009;  // sub0 oe=1, sub1 inv=1
  logic [17:0] CFG_B = 18'h35555;  // all oe=1, sub8 inv=1
  logic [17:0] CFG_C = 18'h15555;  // all oe=1, no inversion
  logic [24:0] OVS_T = 25'h15AC396;
  logic        hist[1:25];

  // Monitor: compare every queued expectation against the settled DUT outputs.
  always @(negedge prog_clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  bad;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      bad = (pad_dir !== e.dir) || (pad_out !== e.out) ||
            (io_inpad_upper !== e.inp) || (io_inpad_lower !== e.inp) ||
            (cfg_valid !== e.vld) || (cfg_err !== e.err) ||
            (e.tail_care && (ccff_tail !== e.tail));
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: actual/required DIR=%h/%h OUT=%h/%h UP=%h/%h LO=%h/%h VLD=%b/%b ERR=%b/%b TAIL=%b/%b(care=%b)",
                 nm, pad_dir, e.dir, pad_out, e.out, io_inpad_upper, e.inp, io_inpad_lower, e.inp,
                 cfg_valid, e.vld, cfg_err, e.err, ccff_tail, e.tail, e.tail_care);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [8:0] dir, input logic [8:0] out,
                          input logic [8:0] inp, input logic vld, input logic err,
                          input logic tail, input logic tc);
    exp_t e;
    e.dir = dir; e.out = out; e.inp = inp;
    e.vld = vld; e.err = err; e.tail = tail; e.tail_care = tc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Push, then idle one cycle so the monitor samples before anything changes.
  task automatic expect_now(input string nm, input logic [8:0] dir, input logic [8:0] out,
                            input logic [8:0] inp, input logic vld, input logic err,
                            input logic tail, input logic tc);
    push_exp(nm, dir, out, inp, vld, err, tail, tc);
    @(posedge prog_clk); #1;
  endtask

  // Shift w[n-1] first down to w[0] last; entered and left at posedge+1.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head = w[i];
      ccff_en   = 1'b1;
      @(posedge prog_clk); #1;
    end
    ccff_en = 1'b0;
  endtask

  task automatic pulse_load();
    ccff_load = 1'b1;
    @(posedge prog_clk); #1;
    ccff_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog_reset_n = 1'b0;
    IO_ISOL_N    = 1'b0;
    ccff_en      = 1'b0;
    ccff_load    = 1'b0;
    ccff_head    = 1'b0;
    pad_in       = '0;
    io_outpad    = '0;
    @(posedge prog_clk); #1;
    expect_now("reset_hold", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    prog_reset_n = 1'b1;
    IO_ISOL_N    = 1'b1;
    expect_now("idle_noload", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load with nothing shifted is a short load.
    pulse_load();
    expect_now("load_empty", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Config A: shift 18, pads stay safe until the commit.
    shift_bits({14'h0, CFG_A}, 18);
    expect_now("A_shifted", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_load();
    expect_now("load_A", 9'h1FE, 9'h000, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
    io_outpad = 9'h001;
    expect_now("A_out0", 9'h1FE, 9'h001, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
    io_outpad = 9'h1FF;
    expect_now("A_out_oe_only", 9'h1FE, 9'h001, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
    io_outpad = 9'h000;
    pad_in    = 9'h002;
    expect_now("A_in1_high", 9'h1FE, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    pad_in    = 9'h000;
    expect_now("A_in1_low", 9'h1FE, 9'h000, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
    pad_in    = 9'h1FF;
    expect_now("A_in_all", 9'h1FE, 9'h000, 9'h1FC, 1'b1, 1'b0, 1'b0, 1'b1);
    pad_in    = 9'h000;

    // Short shift of 17: refused, A stays on the pads; tail now holds A[0].
    shift_bits({15'h0, CFG_B[16:0]}, 17);
    pulse_load();
    expect_now("short17", 9'h1FE, 9'h000, 9'h002, 1'b1, 1'b1, 1'b1, 1'b1);

    // Full config B.
    shift_bits({14'h0, CFG_B}, 18);
    expect_now("B_shifted_old_pads", 9'h1FE, 9'h000, 9'h002, 1'b1, 1'b1, 1'b1, 1'b1);
    pulse_load();
    expect_now("load_B", 9'h000, 9'h100, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
    io_outpad = 9'h0F0;
    pad_in    = 9'h1FF;
    expect_now("B_inv8", 9'h000, 9'h1F0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
    io_outpad = 9'h000;
    pad_in    = 9'h000;

    // Overshift by 7: tail follows the bit shifted 18 shifts ago.
    for (int k = 1; k <= 25; k++) begin
      hist[k] = OVS_T[25-k];
      shift_bits({31'h0, hist[k]}, 1);
      if (k >= 18)
        expect_now($sformatf("ovs_tail_k%0d", k), 9'h000, 9'h100, 9'h000, 1'b1, 1'b0, hist[k-17], 1'b1);
    end
    pulse_load();
    expect_now("ovs_load", 9'h000, 9'h100, 9'h000, 1'b1, 1'b1, OVS_T[17], 1'b1);

    // Simultaneous en+load at cnt=18: commit wins, no shift happens.
    io_outpad = 9'h0A5;
    shift_bits({14'h0, CFG_C}, 18);
    ccff_head = 1'b1;
    ccff_en   = 1'b1;
    ccff_load = 1'b1;
    @(posedge prog_clk); #1;
    ccff_en   = 1'b0;
    ccff_load = 1'b0;
    expect_now("en_and_load", 9'h000, 9'h0A5, 9'h000, 1'b1, 1'b0, CFG_C[17], 1'b1);

    // Counter restarted by that load: a fresh 18 bits commits cleanly.
    shift_bits({14'h0, CFG_A}, 18);
    pulse_load();
    expect_now("reload_A", 9'h1FE, 9'h001, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);

    // Isolation overrides a live config, then releases it.
    io_outpad = 9'h1FF;
    pad_in    = 9'h1FF;
    IO_ISOL_N = 1'b0;
    expect_now("isolated", 9'h1FF, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    IO_ISOL_N = 1'b1;
    expect_now("deisolated", 9'h1FE, 9'h001, 9'h1FC, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-shift: checked before the next rising edge.
    shift_bits(32'h1F, 5);
    ccff_head    = 1'b1;
    ccff_en      = 1'b1;
    prog_reset_n = 1'b0;
    expect_now("rst_async", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    ccff_en      = 1'b0;
    prog_reset_n = 1'b1;
    expect_now("post_rst", 9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    shift_bits({14'h0, CFG_B}, 18);
    pulse_load();
    expect_now("post_rst_load_B", 9'h000, 9'h0FF, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1);

    @(posedge prog_clk); #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
